// File: rtl/keypad_scanner_n.sv
// keypad_scanner_n: NROWS x NCOLS matrix keypad scanner.
// Drives one column low at a time, samples synchronised active-low rows,
// debounces whole scan frames and reports one key with press/release strobes.
//
// state  | meaning
// S_IDLE | no accepted key held
// S_HELD | accepted key held, key/key_valid reflect it
module keypad_scanner_n #(
    parameter int NROWS          = 4,
    parameter int NCOLS          = 4,
    parameter int DWELL_CYC      = 100000,
    parameter int SETTLE_CYC     = 100,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int HEX_MAP        = 1,
    localparam int KW = (NROWS * NCOLS > 1) ? $clog2(NROWS * NCOLS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NROWS-1:0] row,
    output logic [NCOLS-1:0] col,
    output logic [KW-1:0]    key,
    output logic             key_valid,
    output logic             key_press,
    output logic             key_release,
    output logic             multi
);

    localparam int DW = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
    localparam int CW = (NCOLS > 1) ? $clog2(NCOLS) : 1;
    localparam int RW = (NROWS > 1) ? $clog2(NROWS) : 1;
    localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
    // Two synchroniser flops plus one cycle of column output register must
    // elapse before a sample reflects the driven column.
    localparam int SETTLE_EFF = (SETTLE_CYC < 3) ? 3 : SETTLE_CYC;
    localparam bit USE_HEX = (HEX_MAP == 1) && (NROWS == 4) && (NCOLS == 4);
    // Pmod KYPD legend, indexed by r*4+c.
    localparam int HEX_LUT [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 0, 15, 14, 13};

    // Frame result kinds double as the saturated count of low samples.
    localparam logic [1:0] RES_NONE   = 2'd0;
    localparam logic [1:0] RES_SINGLE = 2'd1;
    localparam logic [1:0] RES_MULTI  = 2'd2;

    typedef enum logic {S_IDLE, S_HELD} state_t;

    function automatic logic [KW-1:0] code_of(input int r, input int c);
        if (USE_HEX) return KW'(HEX_LUT[(r * 4 + c) & 15]);
        else         return KW'(r * NCOLS + c);
    endfunction

    logic [NROWS-1:0] row_m, row_s;
    logic [DW-1:0]    dwell_cnt;
    logic [CW-1:0]    col_idx;
    logic [NCOLS-1:0] col_pat;
    logic             last_dwell, last_col, frame_end, sample;

    logic [1:0]       samp_n;
    logic [RW-1:0]    samp_r;
    logic [2:0]       acc_sum;
    logic [1:0]       acc_n, acc_n_nx;
    logic [KW-1:0]    acc_code, res_code;

    logic [1:0]       prev_kind;
    logic [KW-1:0]    prev_code;
    logic [SW-1:0]    stable_cnt, cnt_nx;
    logic             same;

    logic             acpt_vld;
    logic [1:0]       acpt_kind;
    logic [KW-1:0]    acpt_code;
    state_t           state;

    assign last_dwell = (dwell_cnt == DW'(DWELL_CYC - 1));
    assign last_col   = (col_idx == CW'(NCOLS - 1));
    assign frame_end  = last_dwell && last_col;
    assign sample     = (dwell_cnt == DW'(SETTLE_EFF));

    // Column drive pattern for the current column index.
    always_comb begin
        col_pat = '1;
        for (int k = 0; k < NCOLS; k++) begin
            col_pat[NCOLS-1-k] = (int'(col_idx) != k);
        end
    end

    // Count the low rows in the current sample (saturating at two) and note the first one.
    always_comb begin
        samp_n = 2'd0;
        samp_r = '0;
        for (int r = 0; r < NROWS; r++) begin
            if (!row_s[NROWS-1-r]) begin
                if (samp_n == 2'd0) samp_r = RW'(r);
                if (samp_n != 2'd2) samp_n = samp_n + 2'd1;
            end
        end
    end

    // Frame accumulator update and debounce comparison.
    always_comb begin
        acc_sum  = {1'b0, acc_n} + {1'b0, samp_n};
        acc_n_nx = (acc_sum >= 3'd2) ? 2'd2 : acc_sum[1:0];
        res_code = (acc_n == RES_SINGLE) ? acc_code : '0;
        same     = (acc_n == prev_kind) && (res_code == prev_code);
        if (!same)                                   cnt_nx = '0;
        else if (stable_cnt == SW'(DEBOUNCE_SCANS))  cnt_nx = stable_cnt;
        else                                         cnt_nx = stable_cnt + SW'(1);
    end

    // Row synchroniser; idle level is high (pull-ups).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_m <= '1;
            row_s <= '1;
        end else begin
            row_m <= row;
            row_s <= row_m;
        end
    end

    // Dwell timer and column sequencer; col lags col_idx by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwell_cnt <= '0;
            col_idx   <= '0;
            col       <= '1;
        end else begin
            col <= col_pat;
            if (last_dwell) begin
                dwell_cnt <= '0;
                col_idx   <= last_col ? '0 : col_idx + CW'(1);
            end else begin
                dwell_cnt <= dwell_cnt + DW'(1);
            end
        end
    end

    // Accumulate the frame result from every column sample; cleared at frame end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_n    <= RES_NONE;
            acc_code <= '0;
        end else if (frame_end) begin
            acc_n    <= RES_NONE;
            acc_code <= '0;
        end else if (sample) begin
            acc_n <= acc_n_nx;
            if (acc_n == 2'd0 && samp_n == 2'd1) acc_code <= code_of(int'(samp_r), int'(col_idx));
        end
    end

    // Frame debounce: accept once when a result has repeated enough frames.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_kind  <= RES_NONE;
            prev_code  <= '0;
            stable_cnt <= '0;
            acpt_vld   <= 1'b0;
            acpt_kind  <= RES_NONE;
            acpt_code  <= '0;
        end else begin
            acpt_vld <= 1'b0;
            if (frame_end) begin
                stable_cnt <= cnt_nx;
                if (!same) begin
                    prev_kind <= acc_n;
                    prev_code <= res_code;
                end
                if (cnt_nx == SW'(DEBOUNCE_SCANS - 1)) begin
                    acpt_vld  <= 1'b1;
                    acpt_kind <= acc_n;
                    acpt_code <= res_code;
                end
            end
        end
    end

    // Key state machine with registered outputs and one-cycle strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            key         <= '0;
            key_valid   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            multi       <= 1'b0;
        end else begin
            key_press   <= 1'b0;
            key_release <= 1'b0;
            if (acpt_vld) begin
                if (acpt_kind == RES_MULTI) begin
                    multi <= 1'b1;
                end else if (acpt_kind == RES_NONE) begin
                    multi <= 1'b0;
                    if (state == S_HELD) begin
                        state       <= S_IDLE;
                        key_valid   <= 1'b0;
                        key_release <= 1'b1;
                    end
                end else if (state == S_IDLE) begin
                    state     <= S_HELD;
                    key       <= acpt_code;
                    key_valid <= 1'b1;
                    key_press <= 1'b1;
                    multi     <= 1'b0;
                end else if (acpt_code != key) begin
                    key         <= acpt_code;
                    key_press   <= 1'b1;
                    key_release <= 1'b1;
                    multi       <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner_n.sv
// Bench for keypad_scanner_n: a behavioural keypad drives the rows from the
// set of pressed keys, and a frame-level model predicts strobes and outputs.
module tb_keypad_scanner_n;
    localparam int DB    = 3;
    localparam int FRAME = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row, col, key;
    logic        key_valid, key_press, key_release, multi;
    logic [15:0] mask = '0;

    int total = 0;
    int bad   = 0;
    int lut [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 0, 15, 14, 13};

    logic [15:0] frames [$];

    // Model state: current run of identical frame results and key state.
    int run_kind = 0, run_code = 0, run_len = 1;
    int m_held = 0, m_key = 0, m_multi = 0;

    always #5 clk = ~clk;

    keypad_scanner_n #(
        .NROWS(4), .NCOLS(4), .DWELL_CYC(16), .SETTLE_CYC(4),
        .DEBOUNCE_SCANS(DB), .HEX_MAP(1)
    ) dut (
        .clk(clk), .rst(rst), .row(row), .col(col), .key(key),
        .key_valid(key_valid), .key_press(key_press),
        .key_release(key_release), .multi(multi)
    );

    // Physical keypad: a pressed key shorts its row to its column.
    always_comb begin
        row = '1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (mask[r*4+c] && !col[3-c]) row[3-r] = 1'b0;
    end

    task automatic check_val(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", tag, got, exp);
        end
    endtask

    task automatic model_frame(input logic [15:0] m, output int ep, output int er);
        int n, kind, code;
        n = 0; code = 0; ep = 0; er = 0;
        for (int i = 0; i < 16; i++) if (m[i]) begin n++; code = lut[i]; end
        kind = (n >= 2) ? 2 : n;
        if (kind != 1) code = 0;
        if (kind == run_kind && code == run_code) run_len++;
        else begin run_kind = kind; run_code = code; run_len = 1; end
        if (run_len == DB) begin
            if (kind == 2) m_multi = 1;
            else if (kind == 0) begin
                if (m_held != 0) begin er = 1; m_held = 0; end
                m_multi = 0;
            end else if (m_held == 0) begin
                m_held = 1; m_key = code; ep = 1; m_multi = 0;
            end else if (code != m_key) begin
                ep = 1; er = 1; m_key = code; m_multi = 0;
            end
        end
    endtask

    task automatic push_n(input logic [15:0] m, input int n);
        for (int i = 0; i < n; i++) frames.push_back(m);
    endtask

    initial begin
        int cyc, nf, f, ep, er, n_press, n_rel, n_both;
        int b0, b1, kind, len;

        push_n(16'h0000, 4);                  // idle frames, column order
        push_n(16'h0002, 4);                  // r0c1 -> 2
        push_n(16'h0000, 4);
        push_n(16'h0020, 1); push_n(16'h0000, 1);   // bounce r1c1
        push_n(16'h0020, 1); push_n(16'h0000, 1);
        push_n(16'h0020, 4);                  // settles -> 5
        push_n(16'h0400, 4);                  // direct switch to r2c2 -> 9
        push_n(16'h0000, 4);
        push_n(16'h8001, 4);                  // r0c0 + r3c3 -> multi
        push_n(16'h0001, 4);                  // r0c0 alone -> 1
        push_n(16'h0000, 4);
        for (int s = 0; s < 10; s++) begin
            kind = $urandom_range(0, 2);
            len  = $urandom_range(1, 4);
            b0   = $urandom_range(0, 15);
            b1   = (b0 + $urandom_range(1, 15)) % 16;
            if (kind == 0)      push_n(16'h0000, len);
            else if (kind == 1) push_n(16'(1 << b0), len);
            else                push_n(16'((1 << b0) | (1 << b1)), len);
        end
        push_n(16'h0040, 4);                  // r1c2 held into reset
        nf = frames.size();

        mask = frames[0];
        rst  = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_col", col, 15);
        check_val("rst_key", key, 0);
        check_val("rst_valid", key_valid, 0);
        check_val("rst_press", key_press, 0);
        check_val("rst_multi", multi, 0);
        rst = 1'b0;

        cyc = 0; n_press = 0; n_rel = 0; n_both = 0;
        while (cyc < (nf + 1) * FRAME + 31) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (key_press) n_press++;
            if (key_release) n_rel++;
            if (key_press && key_release) n_both++;
            if (cyc == 1) check_val("col_first", col, 7);
            if (cyc % 16 == 8) check_val("col_order", col, 15 ^ (8 >> ((cyc / 16) % 4)));
            if (cyc % FRAME == 58 && (cyc / FRAME + 1) < nf) mask = frames[cyc / FRAME + 1];
            if (cyc % FRAME == 30 && cyc > FRAME) begin
                f = cyc / FRAME - 1;
                if (f < nf) begin
                    model_frame(frames[f], ep, er);
                    check_val("press_cnt", n_press, ep);
                    check_val("release_cnt", n_rel, er);
                    check_val("press_rel_same", n_both, ep & er);
                    check_val("key", key, m_key);
                    check_val("key_valid", key_valid, m_held);
                    check_val("multi", multi, m_multi);
                end
                n_press = 0; n_rel = 0; n_both = 0;
            end
        end

        repeat (20) @(negedge clk);
        check_val("held_before_rst", key_valid, 1);
        rst = 1'b1;
        #1;
        check_val("midrst_col", col, 15);
        check_val("midrst_key", key, 0);
        check_val("midrst_valid", key_valid, 0);
        check_val("midrst_multi", multi, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_val("post_rst_col", col, 7);
        check_val("post_rst_press", key_press, 0);
        check_val("post_rst_release", key_release, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
